ram_arbiter: RTL and testbench

//  Shares the single-port data RAM between two requesters: port 0 = CPU load/store path,

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 16 +
 rtl/ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding, port indices and RAM mode constants for ram_arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;

    localparam logic [1:0] MODE_WORD = 2'd0;
    localparam logic [1:0] MODE_HALF = 2'd1;
    localparam logic [1:0] MODE_BYTE = 2'd2;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
    import arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic win_o,
    output logic valid_o
);

    // On a tie the port that did not win last time goes next.
    assign valid_o = req0_i | req1_i;
    assign win_o   = (req0_i && req1_i) ? ~last_i : (req1_i ? P_DBG : P_CPU);

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin sharing of one single-port RAM between CPU and debug scanner
// Optional ARB_PERF_EN adds the conflict_cnt output.
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        mode0,
    input  logic [1:0]        mode1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic [1:0]        ram_mode,
    output logic              ram_we,
`ifdef ARB_PERF_EN
    output logic [31:0]       conflict_cnt,
`endif
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [1:0]        mode_q, mode_d;
    logic              pick_win, pick_valid, load;

    rr_pick2 u_pick (
        .req0_i  (req0),
        .req1_i  (req1),
        .last_i  (last_q),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        mode_d  = mode_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    load    = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                load    = pick_valid;
                state_d = pick_valid ? ST_ACCESS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Command fields are frozen here; later changes by the requester are ignored.
        if (load) begin
            win_d  = pick_win;
            last_d = pick_win;
            if (pick_win == P_DBG) begin
                we_d   = we1;
                addr_d = addr1;
                din_d  = wdata1;
                mode_d = mode1;
            end else begin
                we_d   = we0;
                addr_d = addr0;
                din_d  = wdata0;
                mode_d = mode0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            last_q  <= P_DBG;
            win_q   <= P_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            mode_q  <= MODE_WORD;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            mode_q  <= mode_d;
        end
    end

    assign gnt0     = (state_q == ST_ACCESS) && (win_q == P_CPU);
    assign gnt1     = (state_q == ST_ACCESS) && (win_q == P_DBG);
    assign rvalid0  = (state_q == ST_RESP) && (win_q == P_CPU);
    assign rvalid1  = (state_q == ST_RESP) && (win_q == P_DBG);
    assign rdata0   = (rvalid0 && !we_q) ? ram_dout : '0;
    assign rdata1   = (rvalid1 && !we_q) ? ram_dout : '0;
    assign ram_addr = addr_q;
    assign ram_din  = din_q;
    assign ram_mode = mode_q;
    assign ram_we   = (state_q == ST_ACCESS) && we_q;

`ifdef ARB_PERF_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (req0 && req1 && (state_q == ST_IDLE || state_q == ST_RESP)
            && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter (vector table, corner sequences, random model)
module tb_ram_arbiter;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  t_req, t_we;
    logic [11:0] t_addr [2];
    logic [31:0] t_wdata [2];
    logic [1:0]  t_mode [2];
    logic        gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [31:0] rdata0, rdata1, ram_din, ram_dout;
    logic [11:0] ram_addr;
    logic [1:0]  ram_mode;
`ifdef ARB_PERF_EN
    logic [31:0] conflict_cnt;
`endif

    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [0:4095];
    logic [31:0] shadow [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .clr(clr),
        .req0(t_req[0]), .req1(t_req[1]),
        .addr0(t_addr[0]), .addr1(t_addr[1]),
        .wdata0(t_wdata[0]), .wdata1(t_wdata[1]),
        .we0(t_we[0]), .we1(t_we[1]),
        .mode0(t_mode[0]), .mode1(t_mode[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_mode(ram_mode), .ram_we(ram_we),
`ifdef ARB_PERF_EN
        .conflict_cnt(conflict_cnt),
`endif
        .ram_dout(ram_dout)
    );

    // Synchronous RAM: data for an address appears the cycle after it is presented.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mode;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic p, input logic r, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic [1:0] m);
        t_req[p] = r; t_we[p] = w; t_addr[p] = a; t_wdata[p] = d; t_mode[p] = m;
    endtask

    task automatic rnd_fields(input logic p);
        t_we[p]    = 1'($urandom_range(0, 1));
        t_addr[p]  = 12'($urandom_range(0, 31));
        t_wdata[p] = $urandom;
        t_mode[p]  = 2'($urandom_range(0, 2));
    endtask

    function automatic logic [31:0] pre_val(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Fill RAM 0..255 (and the shadow copy) through the bench port.
    task automatic preload();
        pre_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pre_addr  = 12'(i);
            pre_data  = (i == 16) ? 32'hDEADBEEF : pre_val(i);
            shadow[i] = pre_data;
            tick();
        end
        pre_we = 1'b0;
    endtask

    function automatic logic [31:0] ovec();
        return {27'd0, rvalid1, rvalid0, gnt1, gnt0, ram_we};
    endfunction

    vec_t vt[8];

    initial begin
        logic        pend_valid, pend_port, pend_we, was_gnt;
        logic [11:0] pend_addr;
        logic [31:0] pend_wdata;
        logic [1:0]  pend_mode;
        logic        rv_valid, rv_port, model_last;
        logic [31:0] rv_data;
        int          we_cnt;
        logic [1:0]  g_pat [8];
        logic [1:0]  r_pat [8];

        vt[0] = '{1'b0, 1'b0, 12'h010, 32'h0,          MODE_WORD, 32'hDEADBEEF};
        vt[1] = '{1'b1, 1'b1, 12'h0A0, 32'hA5A5_0001, MODE_WORD, 32'h0};
        vt[2] = '{1'b0, 1'b0, 12'h0A0, 32'h0,          MODE_WORD, 32'hA5A5_0001};
        vt[3] = '{1'b1, 1'b0, 12'h010, 32'h0,          MODE_HALF, 32'hDEADBEEF};
        vt[4] = '{1'b0, 1'b1, 12'h0FC, 32'h0000_FFFF, MODE_HALF, 32'h0};
        vt[5] = '{1'b1, 1'b0, 12'h0FC, 32'h0,          MODE_BYTE, 32'h0000_FFFF};
        vt[6] = '{1'b1, 1'b1, 12'h010, 32'h0BAD_F00D, MODE_BYTE, 32'h0};
        vt[7] = '{1'b0, 1'b0, 12'h010, 32'h0,          MODE_WORD, 32'h0BAD_F00D};

        clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        t_req = '0; t_we = '0;
        for (int p = 0; p < 2; p++) begin
            t_addr[p] = '0; t_wdata[p] = '0; t_mode[p] = '0;
        end
        tick();
        preload();

        // Reset held with a pending request: nothing may be granted.
        drive(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, MODE_WORD);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_quiet", ovec(), 32'h0);
            chk("reset_rdata0", rdata0, 32'h0);
        end
        clr = 1'b0;
        tick();
        chk("first_gnt0", ovec(), 32'b00010);
        chk("first_addr", 32'(ram_addr), 32'h010);
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, MODE_WORD);
        tick();
        chk("first_rvalid0", ovec(), 32'b01000);
        chk("first_rdata0", rdata0, 32'hDEADBEEF);
        tick();

        // Isolated single transactions from IDLE.
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].port, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].mode);
            tick();
            chk($sformatf("vec%0d_gnt", i), ovec(),
                {27'd0, 2'b00, vt[i].port, ~vt[i].port, vt[i].we});
            chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vt[i].addr));
            chk($sformatf("vec%0d_mode", i), 32'(ram_mode), 32'(vt[i].mode));
            if (vt[i].we) chk($sformatf("vec%0d_din", i), ram_din, vt[i].wdata);
            drive(vt[i].port, 1'b0, 1'b0, 12'h0, 32'h0, MODE_WORD);
            tick();
            chk($sformatf("vec%0d_rvalid", i), ovec(),
                {27'd0, vt[i].port, ~vt[i].port, 3'b000});
            chk($sformatf("vec%0d_rdata", i), vt[i].port ? rdata1 : rdata0, vt[i].exp_rdata);
            tick();
            chk($sformatf("vec%0d_idle", i), ovec(), 32'h0);
        end

        // Both ports requesting continuously from reset: strict alternation, CPU first.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 12'h0A0, 32'h0, MODE_WORD);
        drive(1'b1, 1'b1, 1'b0, 12'h0FC, 32'h0, MODE_WORD);
        g_pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        r_pat = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("conf%0d_gnt", i), 32'({gnt1, gnt0}), 32'(g_pat[i]));
            chk($sformatf("conf%0d_rvalid", i), 32'({rvalid1, rvalid0}), 32'(r_pat[i]));
            if (rvalid0) chk("conf_rdata0", rdata0, 32'hA5A5_0001);
            if (rvalid1) chk("conf_rdata1", rdata1, 32'h0000_FFFF);
        end
        t_req = '0;
        tick();
        chk("conf_idle", ovec(), 32'h0);

        // Write by debug port, CPU reads the same address one cycle later.
        we_cnt = 0;
        drive(1'b1, 1'b1, 1'b1, 12'h020, 32'h1234_5678, MODE_WORD);
        tick();
        we_cnt += int'(ram_we);
        chk("wr_gnt1", 32'({gnt1, gnt0}), 32'b10);
        drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, MODE_WORD);
        drive(1'b0, 1'b1, 1'b0, 12'h020, 32'h0, MODE_WORD);
        for (int i = 0; i < 4; i++) begin
            tick();
            we_cnt += int'(ram_we);
            if (i == 0) chk("wr_rvalid1", 32'({rvalid1, rvalid0}), 32'b10);
            if (i == 1) begin
                chk("rd_gnt0", 32'({gnt1, gnt0}), 32'b01);
                t_req[0] = 1'b0;
            end
            if (i == 2) begin
                chk("rd_rvalid0", 32'({rvalid1, rvalid0}), 32'b01);
                chk("rd_after_wr", rdata0, 32'h1234_5678);
            end
        end
        chk("we_one_cycle", 32'(we_cnt), 32'd1);

        // Reset on the edge that ends a write's ACCESS cycle.
        drive(1'b0, 1'b1, 1'b1, 12'h030, 32'hCAFE_F00D, MODE_WORD);
        tick();
        chk("clr_gnt0", ovec(), 32'b00011);
        clr = 1'b1;
        t_req = '0;
        tick();
        chk("clr_no_rvalid", ovec(), 32'h0);
        clr = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 12'h030, 32'h0, MODE_WORD);
        drive(1'b1, 1'b1, 1'b0, 12'h020, 32'h0, MODE_WORD);
        tick();
        chk("clr_tie_cpu", 32'({gnt1, gnt0}), 32'b01);
        t_req[0] = 1'b0;
        tick();
        chk("clr_write_done", rdata0, 32'hCAFE_F00D);
        tick();
        chk("clr_then_dbg", 32'({gnt1, gnt0}), 32'b10);
        t_req[1] = 1'b0;
        tick();
        chk("clr_rdata1", rdata1, 32'h1234_5678);
        tick();

`ifdef ARB_PERF_EN
        begin
            int exp_cnt;
            clr = 1'b1;
            tick();
            chk("perf_clear", conflict_cnt, 32'h0);
            clr = 1'b0;
            drive(1'b0, 1'b1, 1'b0, 12'h004, 32'h0, MODE_WORD);
            drive(1'b1, 1'b1, 1'b0, 12'h008, 32'h0, MODE_WORD);
            exp_cnt = 0;
            for (int i = 0; i < 10; i++) begin
                if (!gnt0 && !gnt1) exp_cnt++;
                tick();
            end
            t_req = '0;
            tick();
            chk("perf_count", conflict_cnt, 32'(exp_cnt));
            tick();
            tick();
        end
`endif

        // Randomized traffic against a transaction-level model.
        clr = 1'b1;
        t_req = '0;
        tick();
        preload();
        clr = 1'b0;
        model_last = 1'b1;
        pend_valid = 1'b0; pend_port = 1'b0; pend_we = 1'b0;
        pend_addr = '0; pend_wdata = '0; pend_mode = '0;
        rv_valid = 1'b0; rv_port = 1'b0; rv_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_gnt", 32'({gnt1, gnt0}),
                pend_valid ? (pend_port ? 32'd2 : 32'd1) : 32'd0);
            chk("rnd_rvalid", 32'({rvalid1, rvalid0}),
                rv_valid ? (rv_port ? 32'd2 : 32'd1) : 32'd0);
            if (rv_valid) chk("rnd_rdata", rv_port ? rdata1 : rdata0, rv_data);
            chk("rnd_we", 32'(ram_we), 32'(pend_valid && pend_we));
            if (pend_valid) begin
                chk("rnd_addr", 32'(ram_addr), 32'(pend_addr));
                chk("rnd_mode", 32'(ram_mode), 32'(pend_mode));
                if (pend_we) chk("rnd_din", ram_din, pend_wdata);
            end
            rv_valid = pend_valid;
            rv_port  = pend_port;
            rv_data  = 32'h0;
            if (pend_valid) begin
                if (pend_we) shadow[pend_addr[7:0]] = pend_wdata;
                else         rv_data = shadow[pend_addr[7:0]];
            end
            was_gnt    = pend_valid;
            pend_valid = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (was_gnt && pend_port == 1'(p)) begin
                    t_req[p] = 1'($urandom_range(0, 1));
                    rnd_fields(1'(p));
                end else if (t_req[p]) begin
                    if ($urandom_range(0, 3) == 0) rnd_fields(1'(p));
                end else if ($urandom_range(0, 2) == 0) begin
                    t_req[p] = 1'b1;
                    rnd_fields(1'(p));
                end
            end
            // Arbiter picks on any non-grant cycle; ties go to the port that did not win last.
            if (!was_gnt && (t_req != 2'b00)) begin
                pend_valid = 1'b1;
                pend_port  = (t_req == 2'b11) ? ~model_last : t_req[1];
                model_last = pend_port;
                pend_we    = t_we[pend_port];
                pend_addr  = t_addr[pend_port];
                pend_wdata = t_wdata[pend_port];
                pend_mode  = t_mode[pend_port];
            end
            tick();
        end
        t_req = '0;
        tick();
        tick();
        tick();
        chk("final_idle", ovec(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
